// File: rtl/burst_responder.sv
// burst_responder: target-side responder for the burst_enable / master_busy / slave_busy handshake,
// with per-beat strobes, done/abort pulses and a saturating completed-burst counter.
module burst_responder #(
  parameter int GRANT_LAT = 0,
  parameter int SETUP_CYC = 1,
  parameter int BEATS     = 6,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             burst_enable,
  input  logic             resp_ready,
  output logic             master_busy,
  output logic             slave_busy,
  output logic             beat_valid,
  output logic [IDX_W-1:0] beat_idx,
  output logic             burst_done,
  output logic             burst_abort,
  output logic [15:0]      burst_count
);
  localparam int CNT_MAX = GRANT_LAT > SETUP_CYC ? GRANT_LAT : SETUP_CYC;
  localparam int CNT_W   = CNT_MAX < 2 ? 1 : $clog2(CNT_MAX);
  typedef enum logic [2:0] {IDLE, GRANT, SETUP, DATA, TAIL, ABORT} state_t;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             en_q, rise, last, mb_nx, sb_nx, done_nx, abort_nx;
  logic [IDX_W-1:0] idx_nx;
  logic [15:0]      count_nx;
  assign rise = burst_enable & ~en_q;
  assign last = beat_idx == IDX_W'(BEATS - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      en_q        <= 1'b0;
      master_busy <= 1'b1;
      slave_busy  <= 1'b1;
      beat_valid  <= 1'b0;
      beat_idx    <= '0;
      burst_done  <= 1'b0;
      burst_abort <= 1'b0;
      burst_count <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      en_q        <= burst_enable;
      master_busy <= mb_nx;
      slave_busy  <= sb_nx;
      beat_valid  <= ~sb_nx;
      beat_idx    <= idx_nx;
      burst_done  <= done_nx;
      burst_abort <= abort_nx;
      burst_count <= count_nx;
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mb_nx    = master_busy;
    sb_nx    = slave_busy;
    idx_nx   = beat_idx;
    done_nx  = 1'b0;
    abort_nx = 1'b0;
    count_nx = burst_count;
    // losing burst_enable before the tail abandons the burst; the tail always completes
    if ((state == GRANT || state == SETUP || state == DATA) && !burst_enable) begin
      state_nx = ABORT;
      mb_nx    = 1'b1;
      sb_nx    = 1'b1;
      idx_nx   = '0;
      abort_nx = 1'b1;
    end else begin
      case (state)
        IDLE: if (rise) begin
          if (GRANT_LAT == 0) begin
            mb_nx    = 1'b0;
            state_nx = SETUP;
            cnt_nx   = CNT_W'(SETUP_CYC - 1);
          end else begin
            state_nx = GRANT;
            cnt_nx   = CNT_W'(GRANT_LAT - 1);
          end
        end
        GRANT: if (cnt == '0) begin
          mb_nx    = 1'b0;
          state_nx = SETUP;
          cnt_nx   = CNT_W'(SETUP_CYC - 1);
        end else cnt_nx = cnt - 1'b1;
        SETUP: if (cnt != '0) cnt_nx = cnt - 1'b1;
        else if (resp_ready) begin
          sb_nx    = 1'b0;
          idx_nx   = '0;
          state_nx = DATA;
        end
        // beat_idx only advances when the next beat is actually issued, so it holds through stalls
        DATA: if (!slave_busy) begin
          if (last) begin
            sb_nx    = 1'b1;
            state_nx = TAIL;
          end else if (resp_ready) idx_nx = beat_idx + 1'b1;
          else sb_nx = 1'b1;
        end else if (resp_ready) begin
          sb_nx  = 1'b0;
          idx_nx = beat_idx + 1'b1;
        end
        TAIL: begin
          mb_nx    = 1'b1;
          done_nx  = 1'b1;
          idx_nx   = '0;
          count_nx = burst_count == 16'hFFFF ? burst_count : burst_count + 16'd1;
          state_nx = IDLE;
        end
        ABORT: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_burst_responder.sv
// tb_burst_responder: directed checks of burst_responder with default and long-latency parameters.
module tb_burst_responder;
  logic        clk = 1'b0, rst_n = 1'b0, burst_enable = 1'b0, resp_ready = 1'b1;
  logic        mb, sb, bv, done, abort, mb2, sb2, bv2, done2, abort2;
  logic [2:0]  idx, idx2;
  logic [15:0] cnt, cnt2;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  burst_responder dut (
    .clk(clk), .rst_n(rst_n), .burst_enable(burst_enable), .resp_ready(resp_ready),
    .master_busy(mb), .slave_busy(sb), .beat_valid(bv), .beat_idx(idx),
    .burst_done(done), .burst_abort(abort), .burst_count(cnt)
  );
  burst_responder #(.GRANT_LAT(4), .SETUP_CYC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .burst_enable(burst_enable), .resp_ready(resp_ready),
    .master_busy(mb2), .slave_busy(sb2), .beat_valid(bv2), .beat_idx(idx2),
    .burst_done(done2), .burst_abort(abort2), .burst_count(cnt2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic idle_wait(input int n);
    burst_enable = 1'b0;
    resp_ready   = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  // Phase d is the negedge before edge T+d; the rise is sampled at edge T.
  task automatic full_burst(input int c, input bit with2);
    for (int d = 0; d <= 15; d++) begin
      @(negedge clk);
      if (d == 0) burst_enable = 1'b1;
      chk($sformatf("b%0d mb d%0d", c, d), mb, !(d >= 1 && d <= 8));
      chk($sformatf("b%0d sb d%0d", c, d), sb, !(d >= 2 && d <= 7));
      chk($sformatf("b%0d bv d%0d", c, d), bv, d >= 2 && d <= 7);
      if (d >= 2 && d <= 7) chk($sformatf("b%0d idx d%0d", c, d), idx, d - 2);
      chk($sformatf("b%0d done d%0d", c, d), done, d == 9);
      chk($sformatf("b%0d abort d%0d", c, d), abort, 0);
      chk($sformatf("b%0d cnt d%0d", c, d), cnt, d >= 9 ? c : c - 1);
      if (with2) begin
        chk($sformatf("l mb d%0d", d), mb2, !(d >= 5 && d <= 13));
        chk($sformatf("l sb d%0d", d), sb2, !(d >= 7 && d <= 12));
        if (d >= 7 && d <= 12) chk($sformatf("l idx d%0d", d), idx2, d - 7);
        chk($sformatf("l done d%0d", d), done2, d == 14);
        chk($sformatf("l cnt d%0d", d), cnt2, d >= 14 ? 1 : 0);
      end
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst mb", mb, 1);
    chk("rst sb", sb, 1);
    chk("rst bv", bv, 0);
    chk("rst idx", idx, 0);
    chk("rst done", done, 0);
    chk("rst abort", abort, 0);
    chk("rst cnt", cnt, 0);
    chk("rst mb2", mb2, 1);
    rst_n = 1'b1;
    idle_wait(3);
    full_burst(1, 1'b1);
    idle_wait(3);
    // resp_ready low at edges T+4..T+5 stalls after beat 2
    for (int d = 0; d <= 12; d++) begin
      @(negedge clk);
      burst_enable = 1'b1;
      resp_ready   = !(d == 4 || d == 5);
      chk($sformatf("st sb d%0d", d), sb, !((d >= 2 && d <= 4) || (d >= 7 && d <= 9)));
      chk($sformatf("st mb d%0d", d), mb, !(d >= 1 && d <= 10));
      if (d >= 2 && d <= 9) chk($sformatf("st idx d%0d", d), idx, d <= 4 ? d - 2 : d <= 6 ? 2 : d - 4);
      chk($sformatf("st done d%0d", d), done, d == 11);
      chk($sformatf("st cnt d%0d", d), cnt, d >= 11 ? 2 : 1);
    end
    idle_wait(4);
    // burst_enable low at edge T+6, after beat 3 has transferred
    for (int d = 0; d <= 10; d++) begin
      @(negedge clk);
      burst_enable = d < 6;
      chk($sformatf("ab mb d%0d", d), mb, !(d >= 1 && d <= 6));
      chk($sformatf("ab sb d%0d", d), sb, !(d >= 2 && d <= 6));
      if (d >= 2 && d <= 5) chk($sformatf("ab idx d%0d", d), idx, d - 2);
      if (d >= 7) chk($sformatf("ab idx d%0d", d), idx, 0);
      chk($sformatf("ab abort d%0d", d), abort, d == 7);
      chk($sformatf("ab done d%0d", d), done, 0);
      chk($sformatf("ab cnt d%0d", d), cnt, 2);
    end
    idle_wait(2);
    full_burst(3, 1'b0);
    idle_wait(3);
    full_burst(4, 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk($sformatf("hold mb k%0d", k), mb, 1);
      chk($sformatf("hold done k%0d", k), done, 0);
      chk($sformatf("hold cnt k%0d", k), cnt, 4);
    end
    idle_wait(2);
    full_burst(5, 1'b0);
    idle_wait(3);
    for (int d = 0; d <= 4; d++) begin
      @(negedge clk);
      burst_enable = 1'b1;
    end
    chk("mid sb", sb, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst mb", mb, 1);
    chk("arst sb", sb, 1);
    chk("arst bv", bv, 0);
    chk("arst idx", idx, 0);
    chk("arst cnt", cnt, 0);
    burst_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post done", done, 0);
    chk("post abort", abort, 0);
    full_burst(1, 1'b0);
    idle_wait(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
